// File: rtl/cabac_ctx_init.sv
// cabac_ctx_init
//   At slice start, sweeps all 64 entries of the context-init ROM, converts each
//   packed {m, n} word into an HEVC context state for the current slice QP and
//   writes {valMps, pStateIdx} into the context state RAM.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : one-cycle request, honoured only when idle
//   slice_qp_i    : SliceQpY, captured (clamped to 51) when start_i is accepted
//   rom_en_o/addr : ROM read port (1-cycle latency); rom_data_i returns the word
//   ctx_we_o/addr/data : context RAM write port, addresses 0..63 in order
//   busy_o        : sweep in progress
//   done_o        : one-cycle pulse after the last write
module cabac_ctx_init #(
  parameter int ROM_AW = 6,
  parameter int WORD_W = 16,
  parameter int CTX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [5:0]        slice_qp_i,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [WORD_W-1:0] rom_data_i,
  output logic              ctx_we_o,
  output logic [ROM_AW-1:0] ctx_addr_o,
  output logic [CTX_W-1:0]  ctx_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rom_en;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_busy, r_done;
  logic [5:0]        r_qpc;

  // [0]: rom_data_i valid, [1]: prod/n registered, [2]: ctx write
  logic [2:0]        r_vld_pipe;
  logic [ROM_AW-1:0] r_addr0, r_addr1, r_ctx_addr;
  logic signed [14:0] r_prod;
  logic [7:0]        r_n;
  logic [CTX_W-1:0]  r_ctx_data;

  logic signed [14:0] w_prod;
  logic signed [14:0] w_sh;
  logic signed [15:0] w_sum;
  logic [6:0]         w_pre;
  logic [CTX_W-1:0]   w_ctx;

  // ---------------- FSM next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      S_RUN:   if (r_rom_addr == '1) w_state_nxt = S_DRAIN;
      // leave once the write for the last address is on the bus
      S_DRAIN: if (r_vld_pipe[2] && r_ctx_addr == '1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- datapath ----------------
  // Stage 1: m (signed) * qpc (0..51) fits comfortably in 15 signed bits.
  always_comb begin
    w_prod = $signed({{7{rom_data_i[15]}}, rom_data_i[15:8]}) * $signed({9'd0, r_qpc});
  end

  // Stage 2: floor shift, add offset, clip to 1..126, map to context state.
  always_comb begin
    w_sh  = r_prod >>> 4;
    w_sum = $signed({w_sh[14], w_sh}) + $signed({8'd0, r_n});
    if (w_sum < 16'sd1)        w_pre = 7'd1;
    else if (w_sum > 16'sd126) w_pre = 7'd126;
    else                       w_pre = w_sum[6:0];
    // pre>63 <=> pre[6]; then pre-64 = pre[5:0], otherwise 63-pre = ~pre[5:0]
    w_ctx = {w_pre[6], (w_pre[6] ? w_pre[5:0] : ~w_pre[5:0])};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_qpc      <= '0;
      r_vld_pipe <= '0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_ctx_addr <= '0;
      r_prod     <= '0;
      r_n        <= '0;
      r_ctx_data <= '0;
    end else begin
      // control outputs are registered from the next state
      r_rom_en   <= (w_state_nxt == S_RUN);
      r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done     <= (w_state_nxt == S_DONE);
      r_rom_addr <= (r_state == S_RUN) ? r_rom_addr + 1'b1 : '0;
      if (r_state == S_IDLE && start_i)
        r_qpc <= (slice_qp_i > 6'd51) ? 6'd51 : slice_qp_i;

      r_vld_pipe <= {r_vld_pipe[1:0], r_rom_en};
      r_addr0    <= r_rom_addr;
      // rom_data_i is garbage unless a read was issued last cycle
      if (r_vld_pipe[0]) begin
        r_prod  <= w_prod;
        r_n     <= rom_data_i[7:0];
        r_addr1 <= r_addr0;
      end
      if (r_vld_pipe[1]) begin
        r_ctx_data <= w_ctx;
        r_ctx_addr <= r_addr1;
      end
    end
  end

  assign rom_en_o   = r_rom_en;
  assign rom_addr_o = r_rom_addr;
  assign ctx_we_o   = r_vld_pipe[2];
  assign ctx_addr_o = r_ctx_addr;
  assign ctx_data_o = r_ctx_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_cabac_ctx_init.sv
module tb_cabac_ctx_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  slice_qp_i;
  logic        rom_en_o;
  logic [5:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        ctx_we_o;
  logic [5:0]  ctx_addr_o;
  logic [6:0]  ctx_data_o;
  logic        busy_o;
  logic        done_o;

  cabac_ctx_init dut (
    .clk(clk), .rst(rst), .start_i(start_i), .slice_qp_i(slice_qp_i),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .ctx_we_o(ctx_we_o), .ctx_addr_o(ctx_addr_o), .ctx_data_o(ctx_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ROM, 1-cycle latency, junk when not enabled
  logic [15:0] rom [64];
  always @(posedge clk) rom_data_i <= rom_en_o ? rom[rom_addr_o] : 16'($urandom);

  typedef struct {int cyc; int addr; int data;} exp_t;
  exp_t wq[$];
  int   dq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // hand-computed results for ROM words 0..5 at qpc 26, 51 and 0
  int hand26[6] = '{'h40, 'h00, 'h00, 'h7e, 'h3e, 'h0f};
  int hand51[6] = '{'h40, 'h07, 'h1f, 'h7e, 'h3e, 'h00};
  int hand00[6] = '{'h40, 'h48, 'h60, 'h7e, 'h3e, 'h1f};

  function automatic int model(input logic [15:0] w, input int qp);
    int q, m, n, s, pre;
    q = (qp > 51) ? 51 : qp;
    m = $signed(w[15:8]);
    n = int'(w[7:0]);
    s = m * q;
    s = (s >= 0) ? s / 16 : -((-s + 15) / 16);
    s = s + n;
    pre = (s < 1) ? 1 : ((s > 126) ? 126 : s);
    return (pre > 63) ? (64 + pre - 64 + (pre - 64) - (pre - 64)) : (63 - pre);
  endfunction

  function automatic int expect_word(input int a, input int qp);
    int q;
    q = (qp > 51) ? 51 : qp;
    if (a < 6) begin
      if (q == 26) return hand26[a];
      if (q == 51) return hand51[a];
      if (q == 0)  return hand00[a];
    end
    return model(rom[a], qp);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (ctx_we_o) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", int'(ctx_addr_o), e.addr);
        chk("wr_data", int'(ctx_data_o), e.data);
      end
    end
    if (done_o) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  // Called just after a negedge (cycle C0). Returns just after the negedge of C69.
  task automatic sweep(input int qp, input bit pokes, input int rst_at);
    int e0;
    start_i = 1'b1;
    slice_qp_i = 6'(qp);
    e0 = cyc;
    for (int a = 0; a < 64; a++) begin
      if (rst_at == 0 || a + 4 <= rst_at) begin
        exp_t e;
        e.cyc = e0 + 4 + a; e.addr = a; e.data = expect_word(a, qp);
        wq.push_back(e);
      end
    end
    if (rst_at == 0) dq.push_back(e0 + 68);
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      start_i = pokes && (k == 10 || k == 68);
      slice_qp_i = 6'd5;
      if (k == 1) begin
        chk("c1_rom_en", int'(rom_en_o), 1);
        chk("c1_rom_addr", int'(rom_addr_o), 0);
        chk("c1_busy", int'(busy_o), 1);
      end
      if (rst_at == 0) begin
        if (k == 64) begin
          chk("c64_rom_en", int'(rom_en_o), 1);
          chk("c64_rom_addr", int'(rom_addr_o), 63);
        end
        if (k == 65) chk("c65_rom_en", int'(rom_en_o), 0);
        if (k == 67) chk("c67_busy", int'(busy_o), 1);
        if (k == 68) chk("c68_busy", int'(busy_o), 0);
      end else begin
        if (k == rst_at) rst = 1'b1;
        if (k == rst_at + 1) begin
          rst = 1'b0;
          chk("rst_we", int'(ctx_we_o), 0);
          chk("rst_rom_en", int'(rom_en_o), 0);
          chk("rst_busy", int'(busy_o), 0);
        end
      end
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    slice_qp_i = '0;
    rom[0] = 16'h0040; rom[1] = 16'hfb48; rom[2] = 16'hec60;
    rom[3] = 16'h7f7f; rom[4] = 16'h8000; rom[5] = 16'h0a20;
    for (int a = 6; a < 64; a++) rom[a] = {8'(a * 37 + 11), 8'(a * 53)};
    repeat (3) @(negedge clk);
    chk("rst_rom_en0", int'(rom_en_o), 0);
    chk("rst_rom_addr0", int'(rom_addr_o), 0);
    chk("rst_ctx_we0", int'(ctx_we_o), 0);
    chk("rst_ctx_addr0", int'(ctx_addr_o), 0);
    chk("rst_ctx_data0", int'(ctx_data_o), 0);
    chk("rst_busy0", int'(busy_o), 0);
    chk("rst_done0", int'(done_o), 0);
    rst = 1'b0;
    @(negedge clk);
    sweep(26, 1'b1, 0);   // ignored starts in C10 and C68
    sweep(51, 1'b0, 0);   // restart in C69
    sweep(63, 1'b0, 0);   // clamps to 51
    sweep(0,  1'b0, 0);
    sweep(26, 1'b0, 30);  // reset mid-sweep
    sweep(51, 1'b0, 0);   // clean sweep after reset
    repeat (6) @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
